img_stream: RTL and testbench
=============================

IMG_STREAM -- requirements
Module: img_stream

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per pixel.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to stream one frame.
REQ-007 SHALL have port w_busy  input  1  frame memory write in progress.
REQ-008 SHALL have port r_addr  output  $clog2(IMG_WIDTH*IMG_HEIGHT)+1  frame memory read address.
REQ-009 SHALL have port mem_dout  input  DATA_WIDTH  frame memory read data, valid exactly 1 cycle after r_addr.
REQ-010 SHALL have port m_data  output  DATA_WIDTH  streamed pixel.
REQ-011 SHALL have port m_valid  output  1  m_data valid.
REQ-012 SHALL have port m_ready  input  1  consumer accepts; a beat transfers when m_valid and m_ready are both high.
REQ-013 SHALL have port m_sof  output  1  beat is pixel (0,0).
REQ-014 SHALL have port m_eol  output  1  beat is the last pixel of a line.
REQ-015 SHALL have port m_eof  output  1  beat is the last pixel of the frame.
REQ-016 SHALL have port busy  output  1  frame in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the final beat transfers.

Function
REQ-018 SHALL implement states IDLE, WAIT, READ, DRAIN.
REQ-019 IDLE: start=1 with w_busy=0 -> READ; start=1 with w_busy=1 -> WAIT; start=0 -> stay.
REQ-020 WAIT: SHALL go to READ on the first cycle w_busy=0; further start pulses SHALL be ignored.
REQ-021 READ: SHALL issue one address per cycle, in raster order (row-major, address = row*IMG_WIDTH + col), while issued-but-untransferred pixels number fewer than 2.
REQ-022 SHALL buffer returned data in a 2-entry FIFO so full throughput (one beat per cycle) is sustained when m_ready is held at 1.
REQ-023 With m_ready=0, m_data and all sideband outputs SHALL hold stable while m_valid=1; no pixel SHALL be lost or duplicated.
REQ-024 Latency: the first m_valid SHALL occur 2 cycles after entry into READ.
REQ-025 After the last address is issued, the block SHALL go to DRAIN and, once the FIFO empties, return to IDLE with done=1 for one cycle.
REQ-026 Column and row counters SHALL wrap: col IMG_WIDTH-1 -> 0 with row+1; the frame end is row IMG_HEIGHT-1, col IMG_WIDTH-1.
REQ-027 m_sof, m_eol and m_eof SHALL travel with their pixel through the FIFO; at the last pixel, m_eol and m_eof SHALL both be 1.
REQ-028 start while busy=1 SHALL be ignored; w_busy rising during READ SHALL NOT stall the stream, since write/read coherence is the system's responsibility.
REQ-029 busy SHALL be 1 in WAIT, READ and DRAIN, and 0 in IDLE.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, counters 0, FIFO empty, r_addr=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, busy=0, done=0.
REQ-031 Reset mid-frame SHALL discard in-flight reads; the first frame after reset SHALL begin at address 0.

Configuration
REQ-032 With macro IMG_STREAM_HFLIP_EN defined, address SHALL be row*IMG_WIDTH + (IMG_WIDTH-1-col), mirroring each line; sideband timing is unchanged.
REQ-033 Without IMG_STREAM_HFLIP_EN, address SHALL follow REQ-021 exactly, and no flip logic SHALL be synthesized.

Verification
REQ-034 Reset mid-READ at pixel 1000, then start -> r_addr restarts at 0 and the first beat has m_sof=1.
REQ-035 IMG_WIDTH=4, IMG_HEIGHT=3, m_ready=1, start -> 12 beats on consecutive cycles equal to mem[0..11], with m_eol on beats 3, 7, 11, m_eof on beat 11, and done 1 cycle after beat 11.
REQ-036 Same frame, m_ready toggling 1,0,0,1 repeating -> data sequence identical to REQ-035 and outputs stable while stalled.
REQ-037 start with w_busy=1 for 5 cycles -> no r_addr change until w_busy falls, then the first beat arrives 2 cycles later.
REQ-038 Second start pulse during READ -> exactly one frame (12 beats) and one done pulse.
REQ-039 IMG_STREAM_HFLIP_EN defined, 4x3 frame -> first line addresses 3, 2, 1, 0, with m_eol on address 0.

Source files
------------

// File: rtl/img_stream.sv
// ---------------------------------------------------------------------------
// img_stream
//
// Reads one frame out of a frame memory in raster order and presents it as
// a valid/ready pixel stream with start-of-frame, end-of-line and
// end-of-frame sideband flags.
//
// Parameters
//   IMG_WIDTH   pixels per line
//   IMG_HEIGHT  lines per frame
//   DATA_WIDTH  bits per pixel
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle request to stream a frame
//   w_busy    frame memory write in progress (delays the start of a frame)
//   r_addr    frame memory read address
//   mem_dout  frame memory read data, valid one cycle after r_addr
//   m_data    streamed pixel
//   m_valid   m_data valid
//   m_ready   consumer accepts the current beat
//   m_sof     beat is pixel (0,0)
//   m_eol     beat is the last pixel of a line
//   m_eof     beat is the last pixel of the frame
//   busy      frame in progress
//   done      one-cycle pulse after the final beat has transferred
//
// Build option
//   IMG_STREAM_HFLIP_EN  when defined, each line is read right-to-left
//                        (horizontal mirror); sideband flags keep their
//                        stream-order meaning.
// ---------------------------------------------------------------------------
module img_stream #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      w_busy,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT):0]     r_addr,
  input  logic [DATA_WIDTH-1:0]                     mem_dout,
  output logic [DATA_WIDTH-1:0]                     m_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic                                      m_sof,
  output logic                                      m_eol,
  output logic                                      m_eof,
  output logic                                      busy,
  output logic                                      done
);

  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W = $clog2(NPIX) + 1;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int ENT_W  = DATA_WIDTH + 3;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] line_base;
  logic [COL_W-1:0]  addr_col;

  logic pend_valid, pend_sof, pend_eol, pend_eof;

  logic [ENT_W-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt;
  logic [ENT_W-1:0] head;

  logic       xfer, issue, col_last, row_last, last_pix;
  logic [1:0] inflight;
  logic       done_next;

  // A beat leaves the block whenever the FIFO holds something and the
  // consumer takes it. The read that is still in the memory pipeline counts
  // towards the outstanding total, and a beat transferring this very cycle
  // frees its slot immediately; that is what lets a 2-entry FIFO sustain one
  // beat per cycle with a one-cycle memory.
  assign m_valid  = (fifo_cnt != 2'd0);
  assign xfer     = m_valid & m_ready;
  assign inflight = fifo_cnt + {1'b0, pend_valid} - {1'b0, xfer};
  assign issue    = (state == READ) && (inflight < 2'd2);

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign last_pix = col_last & row_last;

`ifdef IMG_STREAM_HFLIP_EN
  assign addr_col = COL_LAST - col;
`else
  assign addr_col = col;
`endif

  // The address is only driven while reading so that it sits at zero
  // whenever no frame is being fetched.
  assign r_addr = (state == READ) ? (line_base + ADDR_W'(addr_col)) : '0;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so extra pulses in
  // any other state are ignored. READ ends as soon as the final address is
  // issued; DRAIN waits for the pipeline and FIFO to empty, counting the
  // beat that transfers this cycle as already gone.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = w_busy ? WAIT : READ;
        end
      end
      WAIT: begin
        if (!w_busy) begin
          state_next = READ;
        end
      end
      READ: begin
        if (issue && last_pix) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == 2'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // done is registered so it appears the cycle after the last beat leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= done_next;
    end
  end

  // Raster counters. line_base tracks row*IMG_WIDTH incrementally so no
  // multiplier is needed. They fall back to zero after the final pixel,
  // leaving everything ready for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
    end else if (issue) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row       <= '0;
          line_base <= '0;
        end else begin
          row       <= row + ROW_W'(1);
          line_base <= line_base + LINE_STEP;
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // One-deep tracker for the read currently in the memory pipeline. The
  // sideband flags are captured here so they meet their pixel when the
  // memory data comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_sof   <= 1'b0;
      pend_eol   <= 1'b0;
      pend_eof   <= 1'b0;
    end else begin
      pend_valid <= issue;
      pend_sof   <= (col == '0) && (row == '0);
      pend_eol   <= col_last;
      pend_eof   <= last_pix;
    end
  end

  // Two-entry output FIFO holding {sof, eol, eof, data}. The issue credit
  // guarantees it is never pushed while full. The head entry drives the
  // outputs directly, so they hold steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (pend_valid) begin
        fifo_mem[wr_ptr] <= {pend_sof, pend_eol, pend_eof, mem_dout};
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, pend_valid} - {1'b0, xfer};
    end
  end

  assign head   = fifo_mem[rd_ptr];
  assign m_data = head[DATA_WIDTH-1:0];
  assign m_sof  = m_valid & head[ENT_W-1];
  assign m_eol  = m_valid & head[ENT_W-2];
  assign m_eof  = m_valid & head[ENT_W-3];

endmodule

// File: tb/tb_img_stream.sv
// ---------------------------------------------------------------------------
// tb_img_stream
//
// Testbench for img_stream. A 4x3 instance is driven through full-rate,
// patterned-stall and random-stall frames, a frame delayed by w_busy and a
// mid-frame reset. A 640x480 instance is reset after pixel 1000 has been
// addressed and restarted. Expected beats come from a raster model of the
// frame (address from row/column arithmetic, flags from the pixel index).
// ---------------------------------------------------------------------------
module tb_img_stream;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int N   = W * H;
  localparam int DW  = 8;
  localparam int AW  = $clog2(N) + 1;
  localparam int BW  = 640;
  localparam int BH  = 480;
  localparam int BAW = $clog2(BW * BH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, w_busy, m_ready;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] mem_dout, m_data;
  logic          m_valid, m_sof, m_eol, m_eof, busy, done;

  logic           big_rst, big_start;
  logic [BAW-1:0] big_r_addr;
  logic [DW-1:0]  big_mem_dout, big_m_data;
  logic           big_m_valid, big_m_sof, big_m_eol, big_m_eof, big_busy, big_done;

  logic [DW-1:0] mem [N];

  img_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .w_busy(w_busy),
    .r_addr(r_addr), .mem_dout(mem_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .done(done)
  );

  img_stream #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_WIDTH(DW)) big_dut (
    .clk(clk), .rst(big_rst), .start(big_start), .w_busy(1'b0),
    .r_addr(big_r_addr), .mem_dout(big_mem_dout),
    .m_data(big_m_data), .m_valid(big_m_valid), .m_ready(1'b1),
    .m_sof(big_m_sof), .m_eol(big_m_eol), .m_eof(big_m_eof),
    .busy(big_busy), .done(big_done)
  );

  // Synchronous frame memories with one cycle of read latency.
  always @(posedge clk) mem_dout <= mem[int'(r_addr) % N];
  always @(posedge clk) big_mem_dout <= big_r_addr[7:0] ^ 8'hA5;

  int errors = 0;
  int checks = 0;

  int            cyc = 0;
  int            beat_idx, done_cnt, first_valid_cyc, last_beat_cyc;
  logic          done_exp = 1'b0;
  logic          done_exp_next = 1'b0;
  logic          stalled = 1'b0;
  logic [DW+2:0] held = '0;
  int            t, s_cyc;
  logic [BAW-1:0] big_first;

  // Address of the k-th streamed pixel in raster order.
  function automatic int expAddr(input int k);
    int row, col;
    row = k / W;
    col = k % W;
`ifdef IMG_STREAM_HFLIP_EN
    col = W - 1 - col;
`endif
    return row * W + col;
  endfunction

  // Consumer ready: 0 always ready, 1 the 1,0,0,1 pattern, 2 random.
  function automatic logic readyFor(input int mode, input int k);
    if (mode == 1) return ((k % 4) == 0) || ((k % 4) == 3);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // Low nibble is the address, so every pixel of the frame is distinct.
  task automatic fillMem();
    for (int i = 0; i < N; i++) mem[i] = {4'($urandom_range(0, 15)), 4'(i)};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, check the
  // outputs against the frame model, then wait for the next falling edge.
  task automatic applyStimulus(input logic s, input logic wb, input logic rdy);
    start = s;
    w_busy = wb;
    m_ready = rdy;
    #1;
    checkOutput("done_pulse", 32'(done), 32'(done_exp));
    done_exp_next = 1'b0;
    if (stalled) begin
      checkOutput("stall_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_hold", 32'({m_sof, m_eol, m_eof, m_data}), 32'(held));
    end
    stalled = m_valid && !m_ready;
    held = {m_sof, m_eol, m_eof, m_data};
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid && m_ready) begin
      checkOutput("beat_in_frame", 32'(beat_idx < N), 32'd1);
      if (beat_idx < N) begin
        checkOutput("beat_data", 32'(m_data), 32'(mem[expAddr(beat_idx)]));
        checkOutput("beat_sof", 32'(m_sof), 32'(beat_idx == 0));
        checkOutput("beat_eol", 32'(m_eol), 32'((beat_idx % W) == W - 1));
        checkOutput("beat_eof", 32'(m_eof), 32'(beat_idx == N - 1));
        if (beat_idx == N - 1) begin
          done_exp_next = 1'b1;
          last_beat_cyc = cyc;
        end
      end
      beat_idx++;
    end
    if (done) done_cnt++;
    @(negedge clk);
    cyc++;
    done_exp = done_exp_next;
  endtask

  task automatic clearModel();
    beat_idx = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    last_beat_cyc = -1;
  endtask

  // Stream one frame; a second start is pulsed mid-frame and must be
  // ignored, and w_busy wiggles during the random run without effect.
  task automatic runFrame(input int mode, input string name);
    int k;
    int sc;
    clearModel();
    sc = cyc;
    applyStimulus(1'b1, 1'b0, readyFor(mode, 0));
    checkOutput({name, "_busy"}, 32'(busy), 32'd1);
    k = 1;
    while ((beat_idx < N || done_cnt == 0) && k < 200) begin
      applyStimulus(k == 5, (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0,
                    readyFor(mode, k));
      k++;
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({name, "_beats"}, 32'(beat_idx), 32'(N));
    checkOutput({name, "_done_count"}, 32'(done_cnt), 32'd1);
    checkOutput({name, "_latency"}, 32'(first_valid_cyc - sc), 32'd3);
    if (mode == 0)
      checkOutput({name, "_back_to_back"}, 32'(last_beat_cyc - first_valid_cyc), 32'(N - 1));
    checkOutput({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_r_addr"}, 32'(r_addr), 32'd0);
    checkOutput({name, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({name, "_m_data"}, 32'(m_data), 32'd0);
    checkOutput({name, "_flags"}, 32'({m_sof, m_eol, m_eof}), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    w_busy = 1'b0;
    m_ready = 1'b0;
    big_rst = 1'b1;
    big_start = 1'b0;
    clearModel();
    fillMem();

    @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] full-rate frame");
    runFrame(0, "full_rate");

    $display("[TB] frame with ready pattern 1,0,0,1");
    fillMem();
    runFrame(1, "stall_1001");

    $display("[TB] frame with random ready and w_busy");
    fillMem();
    runFrame(2, "random_ready");

    $display("[TB] start while w_busy is high");
    fillMem();
    clearModel();
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) begin
      checkOutput("wait_busy", 32'(busy), 32'd1);
      checkOutput("wait_addr", 32'(r_addr), 32'd0);
      applyStimulus(i == 2, 1'b1, 1'b1);
    end
    s_cyc = cyc;
    t = 0;
    while ((beat_idx < N || done_cnt == 0) && t < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      t++;
    end
    checkOutput("wait_latency", 32'(first_valid_cyc - s_cyc), 32'd3);
    checkOutput("wait_beats", 32'(beat_idx), 32'(N));
    checkOutput("wait_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] reset in the middle of a frame");
    fillMem();
    clearModel();
    applyStimulus(1'b1, 1'b0, 1'b1);
    t = 0;
    while (beat_idx < 5 && t < 50) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      t++;
    end
    checkOutput("midreset_reached", 32'(beat_idx), 32'd5);
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    stalled = 1'b0;
    done_exp = 1'b0;
    done_exp_next = 1'b0;
    runFrame(0, "after_reset");

    $display("[TB] 640x480 reset after pixel 1000");
`ifdef IMG_STREAM_HFLIP_EN
    big_first = BAW'(BW - 1);
`else
    big_first = '0;
`endif
    big_rst = 1'b0;
    @(negedge clk);
    big_start = 1'b1;
    @(negedge clk);
    big_start = 1'b0;
    t = 0;
    while (big_r_addr != BAW'(1000) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("big_reach_1000", 32'(big_r_addr), 32'd1000);
    checkOutput("big_streaming", 32'(big_m_valid), 32'd1);
    big_rst = 1'b1;
    #1;
    checkOutput("big_reset_addr", 32'(big_r_addr), 32'd0);
    checkOutput("big_reset_valid", 32'(big_m_valid), 32'd0);
    checkOutput("big_reset_busy", 32'(big_busy), 32'd0);
    @(negedge clk);
    big_rst = 1'b0;
    big_start = 1'b1;
    @(negedge clk);
    big_start = 1'b0;
    checkOutput("big_restart_addr", 32'(big_r_addr), 32'(big_first));
    @(negedge clk);
    checkOutput("big_no_early_valid", 32'(big_m_valid), 32'd0);
    @(negedge clk);
    checkOutput("big_first_valid", 32'(big_m_valid), 32'd1);
    checkOutput("big_first_sof", 32'(big_m_sof), 32'd1);
    checkOutput("big_first_data", 32'(big_m_data), 32'(big_first[7:0] ^ 8'hA5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
